// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Purpose:
//   Memory stage of the five-stage MIPS pipeline. Takes the EX/MEM pipeline
//   register fields, performs the data-memory access (word and, optionally,
//   sub-word loads and stores) against a local data memory, and registers the
//   results into the MEM/WB pipeline register. Store data can be forwarded
//   from the value currently being written back (w_WD).
//
// Configuration macro:
//   DM_SUBWORD_EN - when defined, lb/lbu/lh/lhu/sb/sh are decoded. When
//                   undefined only lw/sw touch memory; sub-word opcodes do not
//                   write and produce a zero load result.
//
// Parameters:
//   DM_WORDS       - data memory depth in 32-bit words (byte range 0..4*DM_WORDS-1)
//
// Ports:
//   clk            - pipeline clock, rising edge
//   reset          - synchronous, active-high; clears memory and MEM/WB register
//   EXMEM_PC       - PC of the instruction in MEM
//   EXMEM_Instr    - instruction word in MEM
//   EXMEM_WriteReg - destination register of the instruction in MEM
//   EXMEM_Eout     - ALU result / effective byte address
//   EXMEM_RD2      - rt value read in decode, default store data
//   w_WD           - write-back data currently in WB (store forwarding source)
//   MEMWB_PC       - registered PC
//   MEMWB_Instr    - registered instruction
//   MEMWB_WriteReg - registered destination register
//   MEMWB_Eout     - registered ALU result
//   MEMWB_DMout    - registered, extended load data
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EXMEM_PC,
  input  logic [31:0] EXMEM_Instr,
  input  logic [4:0]  EXMEM_WriteReg,
  input  logic [31:0] EXMEM_Eout,
  input  logic [31:0] EXMEM_RD2,
  input  logic [31:0] w_WD,
  output logic [31:0] MEMWB_PC,
  output logic [31:0] MEMWB_Instr,
  output logic [4:0]  MEMWB_WriteReg,
  output logic [31:0] MEMWB_Eout,
  output logic [31:0] MEMWB_DMout
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
`ifdef DM_SUBWORD_EN
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
`endif

  logic [31:0] r_mem [DM_WORDS];
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_writeReg;
  logic [31:0] r_eout;
  logic [31:0] r_dmOut;

  logic [5:0]    w_op;
  logic [4:0]    w_rt;
  logic          w_inRange;
  logic [AW-1:0] w_wordIdx;
  logic          w_isStore;
  logic [31:0]   w_storeData;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_wrData;
  logic [31:0]   w_rdWord;
  logic [31:0]   w_loadData;
`ifdef DM_SUBWORD_EN
  logic [31:0]   w_shifted;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
`endif

  assign w_op      = EXMEM_Instr[31:26];
  assign w_rt      = EXMEM_Instr[20:16];
  assign w_inRange = EXMEM_Eout < 32'(DM_WORDS * 4);
  assign w_wordIdx = EXMEM_Eout[AW+1:2];

  // Store classification is kept apart from lane selection so the forwarding
  // mux below does not form a loop through one combinational block.
  always_comb begin
    w_isStore = 1'b0;
    case (w_op)
      OP_SW:   w_isStore = 1'b1;
`ifdef DM_SUBWORD_EN
      OP_SH,
      OP_SB:   w_isStore = 1'b1;
`endif
      default: w_isStore = 1'b0;
    endcase
  end

  // The instruction now in WB writes its result this cycle, so a store whose
  // rt matches it must take that fresh value instead of the stale RD2.
  assign w_storeData = (w_isStore && (w_rt == r_writeReg) && (r_writeReg != 5'd0))
                       ? w_WD : EXMEM_RD2;

  // Sub-word stores replicate the data into every lane and rely on the byte
  // enables to pick the target lane; misaligned low address bits are ignored.
  always_comb begin
    w_byteEn = 4'b0000;
    w_wrData = w_storeData;
    case (w_op)
      OP_SW: begin
        w_byteEn = 4'b1111;
        w_wrData = w_storeData;
      end
`ifdef DM_SUBWORD_EN
      OP_SH: begin
        w_byteEn = EXMEM_Eout[1] ? 4'b1100 : 4'b0011;
        w_wrData = {2{w_storeData[15:0]}};
      end
      OP_SB: begin
        w_byteEn = 4'b0001 << EXMEM_Eout[1:0];
        w_wrData = {4{w_storeData[7:0]}};
      end
`endif
      default: begin
        w_byteEn = 4'b0000;
        w_wrData = w_storeData;
      end
    endcase
  end

  // Out-of-range addresses read as zero, which also makes every extension of
  // them zero without extra gating.
  assign w_rdWord = w_inRange ? r_mem[w_wordIdx] : 32'd0;

`ifdef DM_SUBWORD_EN
  assign w_shifted = w_rdWord >> {EXMEM_Eout[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = EXMEM_Eout[1] ? w_rdWord[31:16] : w_rdWord[15:0];
`endif

  always_comb begin
    w_loadData = 32'd0;
    case (w_op)
      OP_LW:   w_loadData = w_rdWord;
`ifdef DM_SUBWORD_EN
      OP_LB:   w_loadData = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_loadData = {24'd0, w_byte};
      OP_LH:   w_loadData = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_loadData = {16'd0, w_half};
`endif
      default: w_loadData = 32'd0;
    endcase
  end

  // Reset wins over a store in the same cycle: the MEM instruction is dropped
  // and the whole memory is cleared on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_isStore && w_inRange) begin
      for (int k = 0; k < 4; k++) begin
        if (w_byteEn[k]) begin
          r_mem[w_wordIdx][8*k +: 8] <= w_wrData[8*k +: 8];
        end
      end
    end
  end

  // MEM/WB pipeline register; the PC resets to the boot address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= 32'h0000_3000;
      r_instr    <= 32'd0;
      r_writeReg <= 5'd0;
      r_eout     <= 32'd0;
      r_dmOut    <= 32'd0;
    end else begin
      r_pc       <= EXMEM_PC;
      r_instr    <= EXMEM_Instr;
      r_writeReg <= EXMEM_WriteReg;
      r_eout     <= EXMEM_Eout;
      r_dmOut    <= w_loadData;
    end
  end

  assign MEMWB_PC       = r_pc;
  assign MEMWB_Instr    = r_instr;
  assign MEMWB_WriteReg = r_writeReg;
  assign MEMWB_Eout     = r_eout;
  assign MEMWB_DMout    = r_dmOut;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Purpose:
//   Self-checking bench for mem_stage. A byte-addressed reference model of the
//   data memory and MEM/WB register predicts every output; directed scenarios
//   reproduce the documented examples and a randomized run mixes all opcodes,
//   forwarding, boundary addresses and occasional resets.
//   Honors DM_SUBWORD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DM_BYTES = 12288;
`ifdef DM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;
  localparam logic [5:0] NOP = 6'b000000;

  logic        clk;
  logic        reset;
  logic [31:0] EXMEM_PC;
  logic [31:0] EXMEM_Instr;
  logic [4:0]  EXMEM_WriteReg;
  logic [31:0] EXMEM_Eout;
  logic [31:0] EXMEM_RD2;
  logic [31:0] w_WD;
  logic [31:0] MEMWB_PC;
  logic [31:0] MEMWB_Instr;
  logic [4:0]  MEMWB_WriteReg;
  logic [31:0] MEMWB_Eout;
  logic [31:0] MEMWB_DMout;

  int checks;
  int failures;

  // Reference model state
  logic [7:0]  modelBytes [DM_BYTES];
  logic [31:0] expPC;
  logic [31:0] expInstr;
  logic [4:0]  expWriteReg;
  logic [31:0] expEout;
  logic [31:0] expDM;
  logic [31:0] pcCounter;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .EXMEM_PC       (EXMEM_PC),
    .EXMEM_Instr    (EXMEM_Instr),
    .EXMEM_WriteReg (EXMEM_WriteReg),
    .EXMEM_Eout     (EXMEM_Eout),
    .EXMEM_RD2      (EXMEM_RD2),
    .w_WD           (w_WD),
    .MEMWB_PC       (MEMWB_PC),
    .MEMWB_Instr    (MEMWB_Instr),
    .MEMWB_WriteReg (MEMWB_WriteReg),
    .MEMWB_Eout     (MEMWB_Eout),
    .MEMWB_DMout    (MEMWB_DMout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h0040};
  endfunction

  // Predicts the MEM/WB contents after one edge and updates the byte memory.
  task automatic modelStep(input logic rst, input logic [31:0] instr,
                           input logic [31:0] addr, input logic [31:0] rd2,
                           input logic [4:0] wr, input logic [31:0] wd,
                           input logic [31:0] pc);
    logic [5:0]  op;
    logic [31:0] sd;
    logic [31:0] dm;
    logic        isStore;
    int          a;
    int          w;
    int          h;
    if (rst) begin
      for (int i = 0; i < DM_BYTES; i++) modelBytes[i] = 8'd0;
      expPC = 32'h0000_3000;
      expInstr = 32'd0;
      expWriteReg = 5'd0;
      expEout = 32'd0;
      expDM = 32'd0;
      return;
    end
    op = instr[31:26];
    isStore = (op == SW) || (SUB && (op == SB || op == SH));
    sd = (isStore && instr[20:16] == expWriteReg && expWriteReg != 5'd0) ? wd : rd2;
    dm = 32'd0;
    if (addr < 32'(DM_BYTES)) begin
      a = int'(addr);
      w = a - (a % 4);
      h = a - (a % 2);
      if (op == LW)
        dm = {modelBytes[w+3], modelBytes[w+2], modelBytes[w+1], modelBytes[w]};
      else if (SUB && op == LB)  dm = {{24{modelBytes[a][7]}}, modelBytes[a]};
      else if (SUB && op == LBU) dm = {24'd0, modelBytes[a]};
      else if (SUB && op == LH)  dm = {{16{modelBytes[h+1][7]}}, modelBytes[h+1], modelBytes[h]};
      else if (SUB && op == LHU) dm = {16'd0, modelBytes[h+1], modelBytes[h]};
      if (op == SW) begin
        for (int k = 0; k < 4; k++) modelBytes[w+k] = sd[8*k +: 8];
      end else if (SUB && op == SH) begin
        modelBytes[h] = sd[7:0];
        modelBytes[h+1] = sd[15:8];
      end else if (SUB && op == SB) begin
        modelBytes[a] = sd[7:0];
      end
    end
    expPC = pc;
    expInstr = instr;
    expWriteReg = wr;
    expEout = addr;
    expDM = dm;
  endtask

  // Drives one MEM-stage instruction, advances the model and samples 1ns
  // after the capturing edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                               input logic [31:0] addr, input logic [31:0] rd2,
                               input logic [4:0] wr, input logic [31:0] wd);
    reset = rst;
    EXMEM_PC = pcCounter;
    EXMEM_Instr = instr;
    EXMEM_WriteReg = wr;
    EXMEM_Eout = addr;
    EXMEM_RD2 = rd2;
    w_WD = wd;
    modelStep(rst, instr, addr, rd2, wr, wd, pcCounter);
    pcCounter = pcCounter + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, mkInstr(LW, 5'd1), 32'h10, 32'h1, 5'd7, 32'h2);
    checks++;
    if (MEMWB_PC !== 32'h0000_3000 || MEMWB_Instr !== 32'd0 || MEMWB_WriteReg !== 5'd0 ||
        MEMWB_Eout !== 32'd0 || MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state pc=%h instr=%h wr=%0d eout=%h dm=%h expected pc=00003000 rest 0",
               MEMWB_PC, MEMWB_Instr, MEMWB_WriteReg, MEMWB_Eout, MEMWB_DMout);
    end
  endtask

  task automatic test_word_store_load();
    applyStimulus(1'b0, mkInstr(SW, 5'd9), 32'h10, 32'h12345678, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(LW, 5'd9), 32'h10, 32'h0, 5'd9, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL lw_after_sw got=%h expected=%h", MEMWB_DMout, 32'h12345678);
    end
    checks++;
    if (MEMWB_Eout !== 32'h10 || MEMWB_WriteReg !== 5'd9 || MEMWB_PC !== expPC) begin
      failures++;
      $display("[TB] FAIL passthrough eout=%h wr=%0d pc=%h expected eout=00000010 wr=9 pc=%h",
               MEMWB_Eout, MEMWB_WriteReg, MEMWB_PC, expPC);
    end
    applyStimulus(1'b1, mkInstr(NOP, 5'd0), 32'h0, 32'h0, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(LW, 5'd9), 32'h10, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL lw_after_reset got=%h expected=00000000", MEMWB_DMout);
    end
  endtask

  task automatic test_subword_loads();
    logic [5:0]  ops   [4] = '{LB, LBU, LH, LHU};
    logic [31:0] addrs [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
    logic [31:0] want  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [31:0] exp;
    applyStimulus(1'b0, mkInstr(SW, 5'd2), 32'h20, 32'h80FF7F01, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, mkInstr(ops[i], 5'd2), addrs[i], 32'h0, 5'd0, 32'h0);
      exp = SUB ? want[i] : 32'd0;
      checks++;
      if (MEMWB_DMout !== exp) begin
        failures++;
        $display("[TB] FAIL subword_load_%0d op=%b got=%h expected=%h", i, ops[i], MEMWB_DMout, exp);
      end
    end
  endtask

  task automatic test_subword_stores();
    logic [31:0] exp;
    applyStimulus(1'b0, mkInstr(SW, 5'd2), 32'h40, 32'h0, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(SB, 5'd2), 32'h41, 32'h123456AB, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(SH, 5'd2), 32'h42, 32'h9876CDEF, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(LW, 5'd2), 32'h40, 32'h0, 5'd0, 32'h0);
    exp = SUB ? 32'hCDEFAB00 : 32'd0;
    checks++;
    if (MEMWB_DMout !== exp) begin
      failures++;
      $display("[TB] FAIL subword_store_merge got=%h expected=%h", MEMWB_DMout, exp);
    end
  endtask

  task automatic test_forwarding();
    applyStimulus(1'b0, mkInstr(NOP, 5'd0), 32'h0, 32'h0, 5'd8, 32'h0);
    applyStimulus(1'b0, mkInstr(SW, 5'd8), 32'h4, 32'h0, 5'd0, 32'hDEADBEEF);
    applyStimulus(1'b0, mkInstr(LW, 5'd8), 32'h4, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL forward_wd got=%h expected=deadbeef", MEMWB_DMout);
    end
    applyStimulus(1'b0, mkInstr(SW, 5'd0), 32'h4, 32'h11223344, 5'd0, 32'hFFFFFFFF);
    applyStimulus(1'b0, mkInstr(LW, 5'd0), 32'h4, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL forward_r0_uses_rd2 got=%h expected=11223344", MEMWB_DMout);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus(1'b0, mkInstr(SW, 5'd5), 32'h3000, 32'hA5A5A5A5, 5'd5, 32'h0);
    checks++;
    if (MEMWB_Eout !== 32'h3000 || MEMWB_WriteReg !== 5'd5 || MEMWB_Instr !== expInstr) begin
      failures++;
      $display("[TB] FAIL oor_passthrough eout=%h wr=%0d instr=%h expected eout=00003000 wr=5 instr=%h",
               MEMWB_Eout, MEMWB_WriteReg, MEMWB_Instr, expInstr);
    end
    applyStimulus(1'b0, mkInstr(LW, 5'd5), 32'h3000, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL oor_load got=%h expected=00000000", MEMWB_DMout);
    end
    applyStimulus(1'b0, mkInstr(LW, 5'd5), 32'h0, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL oor_no_wrap_word0 got=%h expected=00000000", MEMWB_DMout);
    end
    applyStimulus(1'b0, mkInstr(LW, 5'd5), 32'h4, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL oor_word4_kept got=%h expected=11223344", MEMWB_DMout);
    end
    applyStimulus(1'b0, mkInstr(SW, 5'd5), 32'h2FFC, 32'h0BADF00D, 5'd0, 32'h0);
    applyStimulus(1'b0, mkInstr(LW, 5'd5), 32'h2FFC, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'h0BADF00D) begin
      failures++;
      $display("[TB] FAIL last_word got=%h expected=0badf00d", MEMWB_DMout);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, mkInstr(SW, 5'd6), 32'h8, 32'h55, 5'd6, 32'h0);
    checks++;
    if (MEMWB_PC !== 32'h0000_3000 || MEMWB_Instr !== 32'd0 || MEMWB_WriteReg !== 5'd0 ||
        MEMWB_Eout !== 32'd0 || MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midstream_reset pc=%h instr=%h wr=%0d eout=%h dm=%h",
               MEMWB_PC, MEMWB_Instr, MEMWB_WriteReg, MEMWB_Eout, MEMWB_DMout);
    end
    applyStimulus(1'b0, mkInstr(LW, 5'd6), 32'h8, 32'h0, 5'd0, 32'h0);
    checks++;
    if (MEMWB_DMout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midstream_no_write got=%h expected=00000000", MEMWB_DMout);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [10] = '{LW, LB, LBU, LH, LHU, SW, SB, SH, NOP, 6'b001000};
    logic [31:0] addr;
    logic        rst;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h2FF0 + 32'($urandom_range(0, 31));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 63));
      endcase
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus(rst, mkInstr(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3))),
                    addr, $urandom, 5'($urandom_range(0, 3)), $urandom);
      checks++;
      if (MEMWB_PC !== expPC || MEMWB_Instr !== expInstr || MEMWB_WriteReg !== expWriteReg ||
          MEMWB_Eout !== expEout || MEMWB_DMout !== expDM) begin
        failures++;
        $display("[TB] FAIL random_%0d got pc=%h instr=%h wr=%0d eout=%h dm=%h expected pc=%h instr=%h wr=%0d eout=%h dm=%h",
                 n, MEMWB_PC, MEMWB_Instr, MEMWB_WriteReg, MEMWB_Eout, MEMWB_DMout,
                 expPC, expInstr, expWriteReg, expEout, expDM);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pcCounter = 32'h0000_3000;
    expWriteReg = 5'd0;
    reset = 1'b1;
    EXMEM_PC = 32'd0;
    EXMEM_Instr = 32'd0;
    EXMEM_WriteReg = 5'd0;
    EXMEM_Eout = 32'd0;
    EXMEM_RD2 = 32'd0;
    w_WD = 32'd0;
    #2;
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_subword_stores();
    test_forwarding();
    test_out_of_range();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
